vga_frame_reader: RTL and testbench

- Pixel-stage block directly downstream of the VGA timing controller.
- Consumes its h_cnt/v_cnt/valid/hsync/vsync.
- Generates the read address into a 320x240 12-bit image ROM/BRAM, upscaled 2x to 640x480.
- Applies an optional per-frame horizontal scroll.
- Aligns sync and blanking with the memory read latency and drives registered 4:4:4 RGB to the DAC pins.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_delay_line.sv | 26 ++
 rtl/vga_frame_reader.sv | 121 ++++++++++++
 tb/tb_vga_frame_reader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and state type for the VGA frame reader
// Contents: display/image geometry, bus widths, reader FSM state enum.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int IMG_W    = 320;
  localparam int IMG_H    = 240;
  localparam int ADDR_W   = 17;
  localparam int RGB_W    = 12;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_t;
endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - resettable fixed-depth shift register
// Ports: clk, reset (sync, active-high), din[WIDTH], dout[WIDTH] = din delayed DEPTH cycles.
// Every stage loads {WIDTH{RESET_VAL}} on reset.
module vga_delay_line #(
  parameter int   WIDTH     = 1,
  parameter int   DEPTH     = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= {WIDTH{RESET_VAL}};
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];
endmodule

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - 2x upscaling image reader with per-frame scroll, sync/RGB alignment
// Ports: pclk, reset (sync, active-high); timing in: valid_in, h_cnt, v_cnt, hsync_in, vsync_in;
//        scroll_en; memory: mem_addr out, mem_data in (MEM_LAT cycles later);
//        DAC out: vga_r/g/b, hsync_out, vsync_out (all PIPE = MEM_LAT+2 cycles behind inputs);
//        frame_tick pulses for one cycle on each vsync falling edge.
// Build option: define VGA_BORDER_EN to paint a white 1-pixel border around the active area.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int MEM_LAT     = 1,
  parameter int SCROLL_STEP = 1
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              scroll_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [RGB_W-1:0]  mem_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_tick
);
  localparam int         PIPE    = MEM_LAT + 2;
  localparam logic [9:0] IMG_W10 = 10'(IMG_W);

  state_t     state;
  logic [8:0] x_off;
  logic       vsync_prev;
  logic       fe;
  logic [9:0] xs;
  logic [9:0] x;
  logic [8:0] y;
  logic [9:0] off_sum;
  logic [1:0] sync_d;

  assign fe = vsync_prev & ~vsync_in;

  // Both operands are < 320, so a single conditional subtract wraps the column.
  always_comb begin
    xs      = {1'b0, 9'(h_cnt >> 1)} + {1'b0, x_off};
    x       = (xs >= IMG_W10) ? xs - IMG_W10 : xs;
    y       = 9'(v_cnt >> 1);
    off_sum = {1'b0, x_off} + 10'(SCROLL_STEP);
  end

  // y*320 + x as shifts; y <= 239 keeps the result within 17 bits.
  always_ff @(posedge pclk) begin
    if (reset) mem_addr <= '0;
    else       mem_addr <= ({8'd0, y} << 8) + ({8'd0, y} << 6) + {7'd0, x};
  end

  // Frame control: scroll offset only moves on the vsync edge, i.e. inside vertical blanking.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= WAIT_FRAME;
      x_off      <= '0;
      vsync_prev <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      frame_tick <= fe;
      if (fe) begin
        if (scroll_en) x_off <= 9'((off_sum >= IMG_W10) ? off_sum - IMG_W10 : off_sum);
        if (state == WAIT_FRAME) state <= ACTIVE;
      end
    end
  end

  vga_delay_line #(.WIDTH(2), .DEPTH(PIPE), .RESET_VAL(1'b1)) u_sync_dly (
    .clk   (pclk),
    .reset (reset),
    .din   ({hsync_in, vsync_in}),
    .dout  (sync_d)
  );
  assign hsync_out = sync_d[1];
  assign vsync_out = sync_d[0];

  // Flags travel PIPE-1 stages so they line up with mem_data at the output register.
`ifdef VGA_BORDER_EN
  localparam int FLAG_W = 2;
  logic [FLAG_W-1:0] flags_in;
  logic [FLAG_W-1:0] flags_d;
  logic              border;
  assign border   = valid_in && (h_cnt == 10'd0 || h_cnt == 10'(H_ACTIVE - 1) ||
                                 v_cnt == 10'd0 || v_cnt == 10'(V_ACTIVE - 1));
  assign flags_in = {border, valid_in};
`else
  localparam int FLAG_W = 1;
  logic [FLAG_W-1:0] flags_in;
  logic [FLAG_W-1:0] flags_d;
  assign flags_in = valid_in;
`endif

  vga_delay_line #(.WIDTH(FLAG_W), .DEPTH(PIPE - 1), .RESET_VAL(1'b0)) u_flag_dly (
    .clk   (pclk),
    .reset (reset),
    .din   (flags_in),
    .dout  (flags_d)
  );

  always_ff @(posedge pclk) begin
    if (reset) begin
      {vga_r, vga_g, vga_b} <= '0;
    end else if (flags_d[0] && state == ACTIVE) begin
`ifdef VGA_BORDER_EN
      {vga_r, vga_g, vga_b} <= flags_d[1] ? 12'hFFF : mem_data;
`else
      {vga_r, vga_g, vga_b} <= mem_data;
`endif
    end else begin
      {vga_r, vga_g, vga_b} <= '0;
    end
  end
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - self-checking bench for vga_frame_reader
module tb_vga_frame_reader;
  localparam int MEM_LAT     = 1;
  localparam int SCROLL_STEP = 1;
  localparam int PIPE        = MEM_LAT + 2;
  localparam int N           = 8192;

  logic        pclk = 1'b0;
  logic        reset, valid_in, hsync_in, vsync_in, scroll_en;
  logic [9:0]  h_cnt, v_cnt;
  logic [16:0] mem_addr;
  logic [11:0] mem_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_out, vsync_out, frame_tick;

  logic        mem_ovr   = 1'b0;
  logic [11:0] mem_const = 12'h000;
  logic [16:0] mem_pipe [MEM_LAT];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int k = 0;
  int m_xoff = 0;
  bit m_active = 0;
  bit m_vsprev = 1;
  bit rst_h [N];
  bit vld_h [N];
  bit bor_h [N];
  bit hs_h  [N];
  bit vs_h  [N];
  bit ovr_h [N];
  logic [11:0] cst_h [N];
  int exp_addr_h [N];

  vga_frame_reader #(.MEM_LAT(MEM_LAT), .SCROLL_STEP(SCROLL_STEP)) dut (
    .pclk       (pclk),
    .reset      (reset),
    .valid_in   (valid_in),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .scroll_en  (scroll_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_tick (frame_tick)
  );

  always #5 pclk = ~pclk;

  // Image content: low address bits folded with the high bits so every address bit matters.
  function automatic logic [11:0] memf(input logic [16:0] a);
    return a[11:0] ^ {7'b0, a[16:12]};
  endfunction

  always @(posedge pclk) begin
    mem_pipe[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_data = mem_ovr ? mem_const : memf(mem_pipe[MEM_LAT-1]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit vld, input int h, input int v,
                      input bit hs, input bit vs, input bit sen);
    int  hh, vv, j, exp_rgb;
    bit  fe, exp_tick, active_pre, clean;
    hh = vld ? h : 0;
    vv = vld ? v : 0;
    reset = rst; valid_in = vld; h_cnt = 10'(hh); v_cnt = 10'(vv);
    hsync_in = hs; vsync_in = vs; scroll_en = sen;
    @(posedge pclk);
    if (k >= N) begin
      $display("FAIL history_overflow cycle=%0d limit=%0d", k, N);
      $fatal(1, "history overflow");
    end
    rst_h[k] = rst; vld_h[k] = vld; hs_h[k] = hs; vs_h[k] = vs;
    ovr_h[k] = mem_ovr; cst_h[k] = mem_const;
    bor_h[k] = vld && (hh == 0 || hh == 639 || vv == 0 || vv == 479);
    exp_addr_h[k] = rst ? 0 : (vv / 2) * 320 + ((hh / 2 + m_xoff) % 320);
    fe = m_vsprev && !vs;
    exp_tick = !rst && fe;
    active_pre = m_active;
    if (rst) begin
      m_xoff = 0; m_active = 0; m_vsprev = 1;
    end else begin
      if (fe) begin
        m_active = 1;
        if (sen) m_xoff = (m_xoff + SCROLL_STEP) % 320;
      end
      m_vsprev = vs;
    end
    // Output after this edge reflects inputs sampled PIPE-1 edges earlier, if no reset since.
    j = k - (PIPE - 1);
    clean = (j >= 0);
    for (int i = (j < 0 ? 0 : j); i <= k; i++) if (rst_h[i]) clean = 0;
    exp_rgb = 0;
    if (clean && vld_h[j] && active_pre) begin
      exp_rgb = ovr_h[k] ? int'(cst_h[k]) : int'(memf(17'(exp_addr_h[j])));
`ifdef VGA_BORDER_EN
      if (bor_h[j]) exp_rgb = 'hFFF;
`endif
    end
    #1;
    check("mem_addr",   32'(mem_addr), 32'(exp_addr_h[k]));
    check("frame_tick", 32'(frame_tick), 32'(exp_tick));
    check("rgb",        32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    check("hsync_out",  32'(hsync_out), clean ? 32'(hs_h[j]) : 32'd1);
    check("vsync_out",  32'(vsync_out), clean ? 32'(vs_h[j]) : 32'd1);
    k++;
  endtask

  task automatic frame_edge(input bit sen);
    step(0, 0, 0, 0, 1, 0, sen);
    step(0, 0, 0, 0, 1, 1, sen);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1, 0);
    // Address corners
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 639, 479, 1, 1, 0);
    step(0, 1, 638, 478, 0, 1, 0);
    // Before first frame edge: black while hsync toggles
    for (int i = 0; i < 20; i++)
      step(0, 1, $urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom), 1, 0);
    frame_edge(0);
    // Randomized traffic, occasional frame edges with random scroll enable
    for (int i = 0; i < 2000; i++)
      step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 639), $urandom_range(0, 479),
           1'($urandom), ($urandom_range(0, 39) != 0), 1'($urandom));
    // Scroll sweep from a clean reset: x_off reaches 319, then wraps to 0
    step(1, 0, 0, 0, 1, 1, 0);
    for (int f = 0; f < 319; f++) begin
      frame_edge(1);
      step(0, 1, 0, 0, 1, 1, 1);
    end
    step(0, 1, 4, 0, 1, 1, 0);
    step(0, 1, 639, 479, 1, 1, 0);
    frame_edge(1);
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 4, 0, 1, 1, 0);
    // Blanking with constant memory data stays black; visible pixels show it
    mem_ovr = 1'b1; mem_const = 12'hABC;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1'($urandom), 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, $urandom_range(0, 639), $urandom_range(0, 479), 1, 1, 0);
    // Reset mid-line, black until the next frame edge
    step(1, 1, 100, 50, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, $urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom), 1, 0);
    frame_edge(0);
    for (int i = 0; i < 6; i++) step(0, 1, $urandom_range(0, 639), $urandom_range(0, 479), 1, 1, 0);
    // Border pixels with black memory
    mem_const = 12'h000;
    step(0, 1, 0, 200, 1, 1, 0);
    step(0, 1, 639, 17, 1, 1, 0);
    step(0, 1, 300, 0, 1, 1, 0);
    step(0, 1, 77, 479, 1, 1, 0);
    step(0, 1, 320, 240, 1, 1, 0);
    step(0, 1, 1, 1, 1, 1, 0);
    step(0, 1, 638, 478, 1, 1, 0);
    for (int i = 0; i < PIPE + 1; i++) step(0, 0, 0, 0, 1, 1, 0);
    mem_ovr = 1'b0;
    for (int i = 0; i < 200; i++)
      step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 639), $urandom_range(0, 479),
           1'($urandom), ($urandom_range(0, 29) != 0), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
